// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory responder: FSM states,
// the NOP instruction word and address helpers.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } imem_state_e;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam int          WORD_BYTES = 4;
   localparam int          CNT_W      = 3;

   // True when the byte address selects a word inside a memory of `depth` words.
   function automatic logic word_in_range(input logic [31:0] addr, input int unsigned depth);
      return ({2'b00, addr[31:2]} < depth);
   endfunction

   // True when the byte address is not aligned to an instruction word.
   function automatic logic misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-write-port, synchronous-read instruction RAM. The read register only
// updates when re is asserted, so a captured word stays put while the
// loader keeps writing. No reset on storage or read register.
module imem_ram #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Write and read on the same edge: a read of the word being written
   // returns the previous contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: accepts one fetch at a time, answers after
// LATENCY cycles, holds the answer until the fetch side takes it.
// Optional statistics counters are enabled by defining INSTR_MEM_STATS_EN.
module instr_mem_responder
   import imem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   input  logic        ld_we,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
`ifdef INSTR_MEM_STATS_EN
   ,
   output logic [31:0] rsp_count,
   output logic [15:0] err_count
`endif
);

   localparam int AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int WAIT_CYC = (LATENCY > 1) ? (LATENCY - 2) : 0;
   localparam logic [CNT_W-1:0] WAIT_INIT = WAIT_CYC[CNT_W-1:0];

   imem_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             sel_ram_q, sel_ram_d;   // response word comes from RAM, not NOP

   logic        req_bad;
   logic        accept;
   logic        ram_re;
   logic        ram_we;
   logic [31:0] ram_rdata;
   logic        unused_ld_lsb;

   assign req_bad   = misaligned(req_addr) || !word_in_range(req_addr, DEPTH_WORDS);
   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign accept    = req_valid && req_ready;
   assign ram_re    = accept && !req_bad;
   // Loader writes are dropped while in reset or when beyond the array.
   assign ram_we    = ld_we && rst_n && word_in_range(ld_addr, DEPTH_WORDS);
   assign unused_ld_lsb = ^ld_addr[1:0];

   imem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ld_addr[AW+1:2]),
      .wdata (ld_data),
      .re    (ram_re),
      .raddr (req_addr[AW+1:2]),
      .rdata (ram_rdata)
   );

   // Next-state logic: capture the request in IDLE, count down in WAIT,
   // present until handshake in RESP.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      sel_ram_d = sel_ram_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               err_d     = req_bad;
               sel_ram_d = !req_bad;
               if (LATENCY == 1) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset discards any outstanding response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         sel_ram_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         sel_ram_q <= sel_ram_d;
      end
   end

   assign rsp_err  = err_q;
   assign rsp_data = sel_ram_q ? ram_rdata : NOP_INSTR;

`ifdef INSTR_MEM_STATS_EN
   logic [31:0] rsp_cnt_q, rsp_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   // Count completed response handshakes; errors saturate.
   always_comb begin
      rsp_cnt_d = rsp_cnt_q;
      err_cnt_d = err_cnt_q;
      if (rsp_valid && rsp_ready) begin
         rsp_cnt_d = rsp_cnt_q + 32'd1;
         if (err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         rsp_cnt_q <= rsp_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign rsp_count = rsp_cnt_q;
   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: two instances (LATENCY 1 and 3)
// share clock, reset, loader and address; each has its own req_valid.
module tb_instr_mem_responder;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid1, req_valid3;
   logic [31:0] req_addr;
   logic        rsp_ready;
   logic        ld_we;
   logic [31:0] ld_addr, ld_data;

   logic        req_ready1, rsp_valid1, rsp_err1;
   logic [31:0] rsp_data1;
   logic        req_ready3, rsp_valid3, rsp_err3;
   logic [31:0] rsp_data3;
`ifdef INSTR_MEM_STATS_EN
   logic [31:0] rsp_count1, rsp_count3;
   logic [15:0] err_count1, err_count3;
`endif

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   instr_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef INSTR_MEM_STATS_EN
      , .rsp_count(rsp_count1), .err_count(err_count1)
`endif
   );

   instr_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef INSTR_MEM_STATS_EN
      , .rsp_count(rsp_count3), .err_count(err_count3)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] o_data(input int lat);
      return (lat == 1) ? rsp_data1 : rsp_data3;
   endfunction
   function automatic logic o_valid(input int lat);
      return (lat == 1) ? rsp_valid1 : rsp_valid3;
   endfunction
   function automatic logic o_err(input int lat);
      return (lat == 1) ? rsp_err1 : rsp_err3;
   endfunction
   function automatic logic o_ready(input int lat);
      return (lat == 1) ? req_ready1 : req_ready3;
   endfunction

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      step();
      ld_we = 1'b0;
   endtask

   // One full fetch: accept, wait lat cycles, check, handshake, check release.
   task automatic txn(input int lat, input logic [31:0] a, input logic [31:0] exp_d,
                      input logic exp_e, input string tag);
      if (lat == 1) req_valid1 = 1'b1; else req_valid3 = 1'b1;
      req_addr = a;
      chk({tag, " req_ready@accept"}, 32'(o_ready(lat)), 32'd1);
      step();
      req_valid1 = 1'b0; req_valid3 = 1'b0;
      req_addr = 32'hFFFF_FFF0;
      for (int i = 1; i < lat; i++) begin
         chk({tag, " rsp_valid early"}, 32'(o_valid(lat)), 32'd0);
         step();
      end
      chk({tag, " rsp_valid"}, 32'(o_valid(lat)), 32'd1);
      chk({tag, " rsp_data"}, o_data(lat), exp_d);
      chk({tag, " rsp_err"}, 32'(o_err(lat)), 32'(exp_e));
      chk({tag, " req_ready in RESP"}, 32'(o_ready(lat)), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, " rsp_valid after hs"}, 32'(o_valid(lat)), 32'd0);
      chk({tag, " req_ready after hs"}, 32'(o_ready(lat)), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; req_valid1 = 1'b0; req_valid3 = 1'b0; req_addr = '0;
      rsp_ready = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      step(); step();
      // Reset state
      chk("rst rsp_valid1", 32'(rsp_valid1), 32'd0);
      chk("rst rsp_valid3", 32'(rsp_valid3), 32'd0);
      chk("rst rsp_err1", 32'(rsp_err1), 32'd0);
      chk("rst rsp_data1", rsp_data1, NOP);
      chk("rst rsp_data3", rsp_data3, NOP);
      rst_n = 1'b1;
      step();
      chk("rst req_ready1", 32'(req_ready1), 32'd1);
      chk("rst req_ready3", 32'(req_ready3), 32'd1);

      load(32'h0000_0000, 32'h0050_0093);
      load(32'h0000_0004, 32'h00A0_0113);
      load(32'h0000_0008, 32'h00C0_0193);
      load(32'h0000_03FC, 32'h0FF0_0513);

      // LATENCY=1 basic fetch
      txn(1, 32'h0, 32'h0050_0093, 1'b0, "L1 addr0");

      // LATENCY=3 fetch with response back-pressure for 5 cycles
      req_valid3 = 1'b1; req_addr = 32'h4;
      step();
      req_valid3 = 1'b0; req_addr = 32'h0;
      chk("L3 N+1 valid", 32'(rsp_valid3), 32'd0);
      chk("L3 N+1 req_ready", 32'(req_ready3), 32'd0);
      step();
      chk("L3 N+2 valid", 32'(rsp_valid3), 32'd0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("L3 hold valid", 32'(rsp_valid3), 32'd1);
         chk("L3 hold data", rsp_data3, 32'h00A0_0113);
         chk("L3 hold err", 32'(rsp_err3), 32'd0);
         chk("L3 hold req_ready", 32'(req_ready3), 32'd0);
         if (i == 1) begin
            // loader rewrites the word and a stray request arrives while held
            ld_we = 1'b1; ld_addr = 32'h4; ld_data = 32'h1234_5678;
            req_valid3 = 1'b1; req_addr = 32'h8;
         end
         step();
         ld_we = 1'b0; req_valid3 = 1'b0;
      end
      rsp_ready = 1'b1;
      chk("L3 hs req_ready", 32'(req_ready3), 32'd0);
      step();
      rsp_ready = 1'b0;
      chk("L3 after hs valid", 32'(rsp_valid3), 32'd0);
      chk("L3 after hs req_ready", 32'(req_ready3), 32'd1);
      txn(3, 32'h4, 32'h1234_5678, 1'b0, "L3 reread addr4");

      // Error and boundary addresses
      txn(1, 32'h2, NOP, 1'b1, "misaligned 0x2");
      txn(1, 32'h400, NOP, 1'b1, "out of range 0x400");
      txn(1, 32'h3FC, 32'h0FF0_0513, 1'b0, "last word 0x3FC");
      txn(3, 32'h401, NOP, 1'b1, "L3 bad 0x401");

      // Read-before-write in the acceptance cycle
      req_valid1 = 1'b1; req_addr = 32'h8;
      ld_we = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
      step();
      req_valid1 = 1'b0; ld_we = 1'b0;
      chk("rbw valid", 32'(rsp_valid1), 32'd1);
      chk("rbw old data", rsp_data1, 32'h00C0_0193);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      txn(1, 32'h8, 32'hDEAD_BEEF, 1'b0, "rbw new data");

      // Reset during WAIT drops the response; loader write in reset ignored
      req_valid3 = 1'b1; req_addr = 32'h0;
      step();
      req_valid3 = 1'b0;
      rst_n = 1'b0;
      ld_we = 1'b1; ld_addr = 32'h0; ld_data = 32'hBAD0_BAD0;
      step();
      rst_n = 1'b1; ld_we = 1'b0;
      chk("rstw req_ready", 32'(req_ready3), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("rstw no rsp", 32'(rsp_valid3), 32'd0);
         step();
      end
      chk("rstw data NOP", rsp_data3, NOP);
      txn(3, 32'h0, 32'h0050_0093, 1'b0, "rstw mem kept");

`ifdef INSTR_MEM_STATS_EN
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("stats rst rsp_count", rsp_count1, 32'd0);
      chk("stats rst err_count", 32'(err_count1), 32'd0);
      txn(1, 32'h0, 32'h0050_0093, 1'b0, "stats g1");
      txn(1, 32'h8, 32'hDEAD_BEEF, 1'b0, "stats g2");
      txn(1, 32'h3FC, 32'h0FF0_0513, 1'b0, "stats g3");
      txn(1, 32'h2, NOP, 1'b1, "stats e1");
      chk("stats rsp_count", rsp_count1, 32'd4);
      chk("stats err_count", 32'(err_count1), 32'd1);
      chk("stats other rsp_count", rsp_count3, 32'd0);
      chk("stats other err_count", 32'(err_count3), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
